booth_op_sequencer: RTL and testbench
=====================================

BOOTH_OP_SEQUENCER -- requirements
Module: booth_op_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits (product width 2N).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort; used only when the macro in REQ-024 is defined.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port clear  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream operand pair is valid.
REQ-006 SHALL have port in_ready  out  1  block can accept an operand pair.
REQ-007 SHALL have port in_mcand, in_mplier  in  N each  signed multiplicand and multiplier.
REQ-008 SHALL have port mul_clear_n  out  1  active-low clear to the Booth multiplier.
REQ-009 SHALL have port mul_start  out  1  one-cycle start pulse to the multiplier.
REQ-010 SHALL have port mul_mcand, mul_mplier  out  N each  operands held stable from ISSUE until the return to IDLE.
REQ-011 SHALL have port mul_done  in  1  multiplier done.
REQ-012 SHALL have port mul_product  in  2N  multiplier result, valid while mul_done=1.
REQ-013 SHALL have port out_valid  out  1; out_product  out  2N; out_err  out  1  downstream result and abort flag.
REQ-014 SHALL have port out_ready  in  1  downstream accepts the result.

Function
REQ-015 SHALL buffer operands in a 2-entry FIFO: push on in_valid&&in_ready; in_ready = !full; data is not lost or reordered.
REQ-016 SHALL run FSM IDLE->ISSUE->START->WAIT->OUT->IDLE.
- IDLE: if FIFO is non-empty, pop into the operand registers and go to ISSUE.
- ISSUE: mul_clear_n=0 for exactly 1 cycle.
- START: mul_start=1 for exactly 1 cycle.
- WAIT: hold until mul_done=1.
REQ-017 SHALL, on the WAIT cycle with mul_done=1, register mul_product into out_product and enter OUT on the next edge.
REQ-018 SHALL hold out_valid=1 with stable out_product/out_err in OUT until out_ready=1, then return to IDLE.
REQ-019 SHALL, on a simultaneous push and pop, perform both; count is unchanged.
REQ-020 SHALL keep mul_start=0 and mul_clear_n=1 outside ISSUE and START, and ignore mul_done outside WAIT.
REQ-021 SHALL give a minimum latency of 4 cycles plus multiplier latency from the accepting edge to out_valid when the FIFO is empty and the FSM is IDLE.

Reset
REQ-022 SHALL, on clear=1 at a rising edge, from any state including mid-WAIT:
- go to IDLE and empty the FIFO;
- set in_ready=1, out_valid=0, out_product=0, out_err=0, mul_start=0;
- drive mul_clear_n=0 while clear=1 and 1 after;
- zero operand outputs and the timeout counter.
REQ-023 SHALL discard any in-flight result; a mul_done arriving after reset is ignored.

Configuration
REQ-024 SHALL, when BOOTH_SEQ_TIMEOUT_EN is defined, count WAIT cycles; if TIMEOUT_CYCLES elapse without mul_done, enter OUT with out_err=1 and out_product=0.
REQ-025 SHALL, when BOOTH_SEQ_TIMEOUT_EN is undefined, tie out_err=0, omit the counter, and wait in WAIT indefinitely.

Structure
REQ-026 SHALL take the FSM state encoding (typedef, 3 bits) and the default N and TIMEOUT_CYCLES constants from shared package booth_pkg.
REQ-027 SHALL implement the operand buffer as sub-module booth_op_fifo (parameter width 2N, depth 2).

Verification (N=8; behavioural multiplier model, done 10 cycles after start)
REQ-028 SHALL check: push mcand=5, mplier=-3 -> mul_clear_n low 1 cycle, mul_start 1 cycle later, out_product=16'hFFF1, out_err=0.
REQ-029 SHALL check: push 3 pairs back-to-back with out_ready=0 -> in_ready=0 after 2 pairs are buffered and the 3rd is held; results come out in order: 7*7=49, -8*-8=64, 127*-128=-16256.
REQ-030 SHALL check: out_ready low 5 cycles -> out_valid and out_product are stable for all 5 cycles; exactly one transfer occurs.
REQ-031 SHALL check: clear=1 for 1 cycle mid-WAIT -> all outputs at reset values, FIFO empty; the late mul_done produces no out_valid.
REQ-032 SHALL check: with BOOTH_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never asserts done -> out_valid on WAIT cycle 16 with out_err=1, out_product=0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared constants and FSM state encoding for the Booth operand sequencer.
//   DEFAULT_N              : default operand width (product is 2*N)
//   DEFAULT_TIMEOUT_CYCLES : default WAIT-cycle limit for the optional timeout
//   seqState_t             : 3-bit sequencer state encoding
package booth_pkg;

   localparam int unsigned DEFAULT_N              = 8;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_OUT   = 3'd4
   } seqState_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Two-entry operand FIFO in front of the sequencer FSM.
// Ports:
//   clk, clear          : clock, synchronous active-high clear (empties FIFO)
//   push, pushData      : write request and data (ignored while full)
//   pop, popData        : read request (ignored while empty) and head data
//   full, empty         : occupancy flags
module booth_op_fifo
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 2 * DEFAULT_N
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wrPtr;
   logic             rdPtr;
   logic [1:0]       count;
   logic             doPush;
   logic             doPop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign doPush  = push && !full;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr];

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (clear) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (doPush) wrPtr <= !wrPtr;
         if (doPop)  rdPtr <= !rdPtr;
         case ({doPush, doPop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: it is only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/booth_op_sequencer.sv
// Booth multiplier operand sequencer: buffers operand pairs, drives the
// multiplier clear/start handshake, and presents each product downstream.
// Optional WAIT timeout enabled by defining BOOTH_SEQ_TIMEOUT_EN.
// Ports:
//   clk, clear                      : clock, synchronous active-high reset
//   in_valid/in_ready               : upstream handshake
//   in_mcand, in_mplier             : signed operands (N bits)
//   mul_clear_n, mul_start          : multiplier clear (active low) and start pulse
//   mul_mcand, mul_mplier           : operands held for the multiplier
//   mul_done, mul_product           : multiplier completion and result (2N bits)
//   out_valid/out_ready             : downstream handshake
//   out_product, out_err            : result and timeout-abort flag
module booth_op_sequencer
   import booth_pkg::*;
#(
   parameter int unsigned N              = DEFAULT_N,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic           clk,
   input  logic           clear,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_mcand,
   input  logic [N-1:0]   in_mplier,
   output logic           mul_clear_n,
   output logic           mul_start,
   output logic [N-1:0]   mul_mcand,
   output logic [N-1:0]   mul_mplier,
   input  logic           mul_done,
   input  logic [2*N-1:0] mul_product,
   output logic           out_valid,
   output logic [2*N-1:0] out_product,
   output logic           out_err,
   input  logic           out_ready
);

   localparam int unsigned PW = 2 * N;

   seqState_t      state;
   seqState_t      nextState;
   logic           fifoFull;
   logic           fifoEmpty;
   logic           fifoPop;
   logic [PW-1:0]  fifoData;
   logic           timeoutHit;

   assign in_ready = !fifoFull;
   assign fifoPop  = (state == ST_IDLE) && !fifoEmpty;

   booth_op_fifo #(
      .WIDTH (PW)
   ) opFifo (
      .clk      (clk),
      .clear    (clear),
      .push     (in_valid),
      .pushData ({in_mcand, in_mplier}),
      .pop      (fifoPop),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

`ifdef BOOTH_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] waitCnt;
   logic             outErrQ;

   // Fires on the last allowed WAIT cycle when the multiplier is still busy.
   assign timeoutHit = (state == ST_WAIT) && !mul_done &&
                       (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign out_err    = outErrQ;

   // WAIT-cycle counter and abort flag.
   always_ff @(posedge clk) begin
      if (clear) begin
         waitCnt <= '0;
         outErrQ <= 1'b0;
      end else begin
         if (state == ST_WAIT) waitCnt <= waitCnt + CNT_W'(1);
         else                  waitCnt <= '0;
         if ((state == ST_WAIT) && mul_done) outErrQ <= 1'b0;
         else if (timeoutHit)                outErrQ <= 1'b1;
      end
   end
`else
   logic unusedTimeout;

   assign timeoutHit    = 1'b0;
   assign out_err       = 1'b0;
   assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (clear) state <= ST_IDLE;
      else       state <= nextState;
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:  if (!fifoEmpty) nextState = ST_ISSUE;
         ST_ISSUE: nextState = ST_START;
         ST_START: nextState = ST_WAIT;
         ST_WAIT:  if (mul_done || timeoutHit) nextState = ST_OUT;
         ST_OUT:   if (out_ready) nextState = ST_IDLE;
         default:  nextState = ST_IDLE;
      endcase
   end

   // Moore outputs; multiplier clear also follows the reset input directly.
   always_comb begin
      mul_clear_n = 1'b1;
      mul_start   = 1'b0;
      out_valid   = 1'b0;
      if (clear || (state == ST_ISSUE)) mul_clear_n = 1'b0;
      if (state == ST_START)            mul_start   = 1'b1;
      if (state == ST_OUT)              out_valid   = 1'b1;
   end

   // Operand hold registers and result capture.
   always_ff @(posedge clk) begin
      if (clear) begin
         mul_mcand   <= '0;
         mul_mplier  <= '0;
         out_product <= '0;
      end else begin
         if (fifoPop) {mul_mcand, mul_mplier} <= fifoData;
         if ((state == ST_WAIT) && mul_done) out_product <= mul_product;
         else if (timeoutHit)                out_product <= '0;
      end
   end

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Self-checking bench for booth_op_sequencer (N=8, TIMEOUT_CYCLES=16) with a
// behavioural multiplier that raises done 10 cycles after start.
module tb_booth_op_sequencer;

   localparam int unsigned N  = 8;
   localparam int unsigned PW = 16;

   logic          clk = 1'b0;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_mcand;
   logic [N-1:0]  in_mplier;
   logic          mul_clear_n;
   logic          mul_start;
   logic [N-1:0]  mul_mcand;
   logic [N-1:0]  mul_mplier;
   logic          mul_done;
   logic [PW-1:0] mul_product;
   logic          out_valid;
   logic [PW-1:0] out_product;
   logic          out_err;
   logic          out_ready;

   int checks    = 0;
   int errors    = 0;
   int transfers = 0;

   // Expected results in issue order: {err, product}.
   logic [16:0] expQ[$];

   logic          modelEnable = 1'b1;
   logic          forceDone   = 1'b0;
   logic          mulDoneM    = 1'b0;
   logic [PW-1:0] mulProdM    = '0;
   int            cd          = 0;
   logic          randReady   = 1'b0;
   logic          randBit     = 1'b0;
   logic          fixedReady  = 1'b0;

   assign mul_done    = mulDoneM | forceDone;
   assign mul_product = mulProdM;
   assign out_ready   = randReady ? randBit : fixedReady;

   booth_op_sequencer #(
      .N              (N),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mcand    (in_mcand),
      .in_mplier   (in_mplier),
      .mul_clear_n (mul_clear_n),
      .mul_start   (mul_start),
      .mul_mcand   (mul_mcand),
      .mul_mplier  (mul_mplier),
      .mul_done    (mul_done),
      .mul_product (mul_product),
      .out_valid   (out_valid),
      .out_product (out_product),
      .out_err     (out_err),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sprod(input logic [7:0] a, input logic [7:0] b);
      int pa;
      int pb;
      pa = int'($signed(a));
      pb = int'($signed(b));
      return 16'(pa * pb);
   endfunction

   // Behavioural Booth multiplier: cleared by mul_clear_n, done 10 cycles after start.
   always @(negedge clk) begin
      if (!mul_clear_n) begin
         cd       = 0;
         mulDoneM = 1'b0;
      end else if (mul_start) begin
         mulProdM = sprod(mul_mcand, mul_mplier);
         cd       = 10;
         mulDoneM = 1'b0;
      end else if (cd > 0) begin
         cd--;
         if (cd == 0 && modelEnable) mulDoneM = 1'b1;
      end
   end

   always @(negedge clk) begin
      randBit = 1'($urandom_range(0, 1));
   end

   // Output scoreboard: each downstream transfer must match the oldest expectation.
   always @(negedge clk) begin
      logic [16:0] e;
      #2;
      if (!clear && out_valid && out_ready) begin
         transfers++;
         checks++;
         assert (expQ.size() > 0) else begin
            errors++;
            $error("FAIL out_unexpected observed=%0h expected=none", out_product);
         end
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("out_product", 64'(out_product), 64'(e[15:0]));
            check("out_err", 64'(out_err), 64'(e[16]));
         end
      end
   end

   task automatic pushPair(input logic [7:0] a, input logic [7:0] b, input logic expErr);
      logic acc;
      acc       = 1'b0;
      in_mcand  = a;
      in_mplier = b;
      in_valid  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         acc = in_ready;
         @(negedge clk);
         if (acc) break;
      end
      in_valid = 1'b0;
      check("push_accept", 64'(acc), 64'(1));
      if (acc) expQ.push_back(expErr ? 17'h10000 : {1'b0, sprod(a, b)});
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (expQ.size() == 0 && !out_valid) break;
         @(negedge clk);
      end
      check(tag, 64'(expQ.size()), 64'(0));
   endtask

   task automatic waitStart(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (mul_start) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check(tag, 64'(seen), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int cnt;
      int issues;
      logic seen;

      clear = 1'b1; in_valid = 1'b0; in_mcand = '0; in_mplier = '0; fixedReady = 1'b0;
      @(negedge clk);
      check("rst_clear_n_low", 64'(mul_clear_n), 64'(0));
      @(negedge clk);
      clear = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_product", 64'(out_product), 64'(0));
      check("rst_out_err", 64'(out_err), 64'(0));
      check("rst_mul_start", 64'(mul_start), 64'(0));
      check("rst_clear_n_high", 64'(mul_clear_n), 64'(1));
      check("rst_mcand", 64'(mul_mcand), 64'(0));
      @(negedge clk);

      // Single multiply 5 * -3 with the clear/start handshake.
      fixedReady = 1'b1;
      pushPair(8'd5, 8'hFD, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!mul_clear_n) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("issue_seen", 64'(seen), 64'(1));
      check("issue_mcand", 64'(mul_mcand), 64'(5));
      check("issue_mplier", 64'(mul_mplier), 64'(8'hFD));
      check("issue_no_start", 64'(mul_start), 64'(0));
      @(negedge clk);
      check("start_pulse", 64'(mul_start), 64'(1));
      check("start_clear_n_high", 64'(mul_clear_n), 64'(1));
      @(negedge clk);
      check("start_single", 64'(mul_start), 64'(0));
      check("hold_mcand", 64'(mul_mcand), 64'(5));
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("first_out_seen", 64'(seen), 64'(1));
      check("first_product", 64'(out_product), 64'(16'hFFF1));
      check("first_err", 64'(out_err), 64'(0));
      drain("drain_first");

      // Three back-to-back pairs with downstream stalled, then a fourth held off.
      fixedReady = 1'b0;
      t0 = transfers;
      pushPair(8'd7, 8'd7, 1'b0);
      pushPair(8'hF8, 8'hF8, 1'b0);
      pushPair(8'd127, 8'h80, 1'b0);
      check("fifo_full_ready", 64'(in_ready), 64'(0));
      in_mcand = 8'($urandom); in_mplier = 8'($urandom); in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held_not_ready", 64'(in_ready), 64'(0));
      end
      fixedReady = 1'b1;
      pushPair(in_mcand, in_mplier, 1'b0);
      drain("drain_order");
      check("order_transfers", 64'(transfers - t0), 64'(4));

      // Back-pressure: result stays put for 5 cycles, then exactly one transfer.
      fixedReady = 1'b0;
      pushPair(8'($urandom), 8'($urandom), 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("bp_out_seen", 64'(seen), 64'(1));
      for (int i = 0; i < 5; i++) begin
         check("bp_valid_held", 64'(out_valid), 64'(1));
         check("bp_product_held", 64'(out_product), 64'(expQ[0][15:0]));
         @(negedge clk);
      end
      t0 = transfers;
      fixedReady = 1'b1;
      @(negedge clk);
      check("bp_valid_dropped", 64'(out_valid), 64'(0));
      repeat (3) @(negedge clk);
      check("bp_one_transfer", 64'(transfers - t0), 64'(1));

      // Clear in the middle of WAIT with a second pair buffered; late done ignored.
      pushPair(8'($urandom), 8'($urandom), 1'b0);
      waitStart("clr_start_seen");
      repeat (3) @(negedge clk);
      pushPair(8'($urandom), 8'($urandom), 1'b0);
      clear = 1'b1;
      #1;
      check("clr_mid_clear_n", 64'(mul_clear_n), 64'(0));
      @(negedge clk);
      clear = 1'b0;
      expQ.delete();
      #1;
      check("clr_in_ready", 64'(in_ready), 64'(1));
      check("clr_out_valid", 64'(out_valid), 64'(0));
      check("clr_out_product", 64'(out_product), 64'(0));
      check("clr_out_err", 64'(out_err), 64'(0));
      check("clr_mul_start", 64'(mul_start), 64'(0));
      check("clr_clear_n", 64'(mul_clear_n), 64'(1));
      check("clr_mcand", 64'(mul_mcand), 64'(0));
      check("clr_mplier", 64'(mul_mplier), 64'(0));
      forceDone = 1'b1;
      cnt = 0;
      issues = 0;
      t0 = transfers;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) cnt++;
         if (!mul_clear_n) issues++;
      end
      forceDone = 1'b0;
      check("late_done_no_valid", 64'(cnt), 64'(0));
      check("fifo_emptied", 64'(issues), 64'(0));
      check("late_done_no_transfer", 64'(transfers - t0), 64'(0));

      // Randomised traffic with random downstream back-pressure.
      t0 = transfers;
      randReady = 1'b1;
      for (int k = 0; k < 20; k++) begin
         pushPair(8'($urandom), 8'($urandom), 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      randReady = 1'b0;
      fixedReady = 1'b1;
      drain("drain_random");
      check("random_transfers", 64'(transfers - t0), 64'(20));

`ifdef BOOTH_SEQ_TIMEOUT_EN
      // Multiplier never completes: abort after 16 WAIT cycles.
      modelEnable = 1'b0;
      pushPair(8'($urandom), 8'($urandom), 1'b1);
      waitStart("to_start_seen");
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) break;
         cnt++;
      end
      check("to_wait_cycles", 64'(cnt), 64'(16));
      check("to_err", 64'(out_err), 64'(1));
      check("to_product", 64'(out_product), 64'(0));
      drain("drain_timeout");
      modelEnable = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
